// File: rtl/csi2_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : csi2_frame_monitor
// Description : Frame monitor placed after the CSI-2 RX decoder. It re-times
//               decoder pixels into a 2-cycle-latency stream with SOF/EOL
//               markers. It measures frame width and height, flags line-length
//               mismatches and strobe-ordering violations, runs a stall
//               watchdog, and keeps frame, ECC and CRC counters.
// Ports       : PARALLEL_CLOCK_I/RESET_I  clock, sync active-high reset
//               FRAME_*/LINE_* _I         decoder FS/FE/LS/LE strobes
//               LINE_VALID_I/DATA_I       decoder pixel stream
//               ECC_ERROR_I/CRC_ERROR_I   decoder error pulses
//               CLEAR_I                   clears statistics counters
//               PIX_*/SOF_O/EOL_O         re-timed pixel stream
//               WIDTH_O/HEIGHT_O/FRAME_*  per-frame geometry and status
//               PROTO_ERR_O/TIMEOUT_O     ordering / watchdog pulses
//               *_CNT_O                   statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module csi2_frame_monitor #(
   parameter int g_DATAWIDTH = 10,
   parameter int g_CNT_WIDTH = 16,
   parameter int g_TIMEOUT   = 1048575
) (
   input  logic                   PARALLEL_CLOCK_I,
   input  logic                   RESET_I,
   input  logic                   FRAME_START_I,
   input  logic                   FRAME_END_I,
   input  logic                   LINE_START_I,
   input  logic                   LINE_END_I,
   input  logic                   LINE_VALID_I,
   input  logic [g_DATAWIDTH-1:0] DATA_I,
   input  logic                   ECC_ERROR_I,
   input  logic                   CRC_ERROR_I,
   input  logic                   CLEAR_I,
   output logic                   PIX_VALID_O,
   output logic [g_DATAWIDTH-1:0] PIX_DATA_O,
   output logic                   SOF_O,
   output logic                   EOL_O,
   output logic [g_CNT_WIDTH-1:0] WIDTH_O,
   output logic [g_CNT_WIDTH-1:0] HEIGHT_O,
   output logic                   FRAME_DONE_O,
   output logic                   FRAME_ERR_O,
   output logic                   PROTO_ERR_O,
   output logic                   TIMEOUT_O,
   output logic [g_CNT_WIDTH-1:0] FRAME_CNT_O,
   output logic [g_CNT_WIDTH-1:0] ECC_CNT_O,
   output logic [g_CNT_WIDTH-1:0] CRC_CNT_O
);

   localparam logic [g_CNT_WIDTH-1:0] c_CNT_ONE = g_CNT_WIDTH'(1);
   localparam logic [19:0]            c_WD_LAST = 20'(g_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_WAIT_FS = 2'd0,
      ST_FRAME   = 2'd1,
      ST_LINE    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [g_CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
   logic [g_CNT_WIDTH-1:0] width_reg_q, width_reg_d;
   logic                   first_line_q, first_line_d, frame_err_q, frame_err_d;
   logic                   sof_pend_q, sof_pend_d;
   logic [19:0]            wd_cnt_q, wd_cnt_d;
   logic                   s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
   logic                   s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d;
   logic [g_DATAWIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
   logic [g_CNT_WIDTH-1:0] width_o_q, width_o_d, height_o_q, height_o_d;
   logic                   frame_done_q, frame_done_d, frame_err_o_q, frame_err_o_d;
   logic                   proto_err_q, proto_err_d, timeout_q, timeout_d;
   logic [g_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, ecc_cnt_q, ecc_cnt_d;
   logic [g_CNT_WIDTH-1:0] crc_cnt_q, crc_cnt_d;

   logic                   accept, restart, complete, open_line, close_line, err_set;
   logic                   activity;
   logic [g_CNT_WIDTH-1:0] pix_total;

   // Pixel count including a pixel presented in the current cycle, so a line
   // whose LE coincides with its last pixel measures its true length.
   assign pix_total = pix_cnt_q + (LINE_VALID_I ? c_CNT_ONE : '0);
   assign activity  = FRAME_START_I | FRAME_END_I | LINE_START_I | LINE_END_I | LINE_VALID_I;

   always_comb begin
      state_d       = state_q;
      pix_cnt_d     = pix_cnt_q;
      line_cnt_d    = line_cnt_q;
      width_reg_d   = width_reg_q;
      first_line_d  = first_line_q;
      sof_pend_d    = sof_pend_q;
      wd_cnt_d      = wd_cnt_q;
      width_o_d     = width_o_q;
      height_o_d    = height_o_q;
      frame_err_o_d = frame_err_o_q;
      frame_done_d  = 1'b0;
      proto_err_d   = 1'b0;
      timeout_d     = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      ecc_cnt_d     = ecc_cnt_q;
      crc_cnt_d     = crc_cnt_q;
      s1_valid_d    = 1'b0;
      s1_data_d     = '0;
      s1_sof_d      = 1'b0;
      s2_valid_d    = s1_valid_q;
      s2_data_d     = s1_data_q;
      s2_sof_d      = s1_sof_q;
      accept        = 1'b0;
      restart       = 1'b0;
      complete      = 1'b0;
      open_line     = 1'b0;
      close_line    = 1'b0;
      err_set       = 1'b0;

      // Strobe decode, priority FS > FE > LE > LS. LE+LS closes and reopens.
      case (state_q)
         ST_WAIT_FS: begin
            restart = FRAME_START_I;
         end
         ST_FRAME: begin
            if (FRAME_START_I) begin
               restart     = 1'b1;
               proto_err_d = 1'b1;
            end else if (FRAME_END_I) begin
               complete = 1'b1;
            end else begin
               if (LINE_END_I) begin
                  proto_err_d = 1'b1;
                  err_set     = 1'b1;
               end
               if (LINE_START_I) begin
                  open_line = 1'b1;
                  accept    = LINE_VALID_I;
               end
            end
         end
         ST_LINE: begin
            accept = LINE_VALID_I;
            if (FRAME_START_I) begin
               restart     = 1'b1;
               proto_err_d = 1'b1;
            end else if (FRAME_END_I) begin
               close_line  = 1'b1;
               complete    = 1'b1;
               proto_err_d = 1'b1;
               err_set     = 1'b1;
            end else begin
               close_line = LINE_END_I;
               if (LINE_START_I) begin
                  open_line = 1'b1;
                  if (!LINE_END_I) proto_err_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      frame_err_d = frame_err_q | err_set | (CRC_ERROR_I & (state_q != ST_WAIT_FS));

      if (close_line) begin
         line_cnt_d = line_cnt_q + c_CNT_ONE;
         if (first_line_q) begin
            width_reg_d  = pix_total;
            first_line_d = 1'b0;
         end else if (pix_total != width_reg_q) begin
            frame_err_d = 1'b1;
         end
      end

      if (accept) pix_cnt_d = pix_total;
      // A pixel alongside LE+LS belongs to the line being closed.
      if (open_line) pix_cnt_d = (accept && !close_line) ? c_CNT_ONE : '0;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = DATA_I;
         s1_sof_d   = sof_pend_q;
         sof_pend_d = 1'b0;
      end

      if (complete) begin
         state_d       = ST_WAIT_FS;
         frame_done_d  = 1'b1;
         width_o_d     = width_reg_d;
         height_o_d    = line_cnt_d;
         frame_err_o_d = frame_err_d;
         frame_cnt_d   = frame_cnt_q + c_CNT_ONE;
      end else if (restart) begin
         state_d      = ST_FRAME;
         pix_cnt_d    = '0;
         line_cnt_d   = '0;
         width_reg_d  = '0;
         first_line_d = 1'b1;
         frame_err_d  = 1'b0;
         sof_pend_d   = 1'b1;
      end else if (open_line) begin
         state_d = ST_LINE;
      end else if (close_line) begin
         state_d = ST_FRAME;
      end

      // Watchdog only advances on fully idle cycles, so it never races a strobe.
      if (state_q == ST_WAIT_FS || activity) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q == c_WD_LAST) begin
         wd_cnt_d  = '0;
         timeout_d = 1'b1;
         state_d   = ST_WAIT_FS;
      end else begin
         wd_cnt_d = wd_cnt_q + 20'd1;
      end

      if (CLEAR_I) begin
         frame_cnt_d = '0;
         ecc_cnt_d   = '0;
         crc_cnt_d   = '0;
      end else begin
         if (ECC_ERROR_I && (ecc_cnt_q != '1)) ecc_cnt_d = ecc_cnt_q + c_CNT_ONE;
         if (CRC_ERROR_I && (crc_cnt_q != '1)) crc_cnt_d = crc_cnt_q + c_CNT_ONE;
      end
   end

   always_ff @(posedge PARALLEL_CLOCK_I) begin
      if (RESET_I) begin
         state_q       <= ST_WAIT_FS;
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         width_reg_q   <= '0;
         first_line_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         sof_pend_q    <= 1'b0;
         wd_cnt_q      <= '0;
         s1_valid_q    <= 1'b0;
         s1_data_q     <= '0;
         s1_sof_q      <= 1'b0;
         s2_valid_q    <= 1'b0;
         s2_data_q     <= '0;
         s2_sof_q      <= 1'b0;
         width_o_q     <= '0;
         height_o_q    <= '0;
         frame_done_q  <= 1'b0;
         frame_err_o_q <= 1'b0;
         proto_err_q   <= 1'b0;
         timeout_q     <= 1'b0;
         frame_cnt_q   <= '0;
         ecc_cnt_q     <= '0;
         crc_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         pix_cnt_q     <= pix_cnt_d;
         line_cnt_q    <= line_cnt_d;
         width_reg_q   <= width_reg_d;
         first_line_q  <= first_line_d;
         frame_err_q   <= frame_err_d;
         sof_pend_q    <= sof_pend_d;
         wd_cnt_q      <= wd_cnt_d;
         s1_valid_q    <= s1_valid_d;
         s1_data_q     <= s1_data_d;
         s1_sof_q      <= s1_sof_d;
         s2_valid_q    <= s2_valid_d;
         s2_data_q     <= s2_data_d;
         s2_sof_q      <= s2_sof_d;
         width_o_q     <= width_o_d;
         height_o_q    <= height_o_d;
         frame_done_q  <= frame_done_d;
         frame_err_o_q <= frame_err_o_d;
         proto_err_q   <= proto_err_d;
         timeout_q     <= timeout_d;
         frame_cnt_q   <= frame_cnt_d;
         ecc_cnt_q     <= ecc_cnt_d;
         crc_cnt_q     <= crc_cnt_d;
      end
   end

   assign PIX_VALID_O  = s2_valid_q;
   assign PIX_DATA_O   = s2_data_q;
   assign SOF_O        = s2_valid_q & s2_sof_q;
   // Last pixel of a line: nothing follows it one stage behind.
   assign EOL_O        = s2_valid_q & ~s1_valid_q;
   assign WIDTH_O      = width_o_q;
   assign HEIGHT_O     = height_o_q;
   assign FRAME_DONE_O = frame_done_q;
   assign FRAME_ERR_O  = frame_err_o_q;
   assign PROTO_ERR_O  = proto_err_q;
   assign TIMEOUT_O    = timeout_q;
   assign FRAME_CNT_O  = frame_cnt_q;
   assign ECC_CNT_O    = ecc_cnt_q;
   assign CRC_CNT_O    = crc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi2_frame_monitor
// Description : Self-checking bench for csi2_frame_monitor. Pixel beats are
//               checked against a scoreboard queue (data, SOF, EOL, cycle);
//               frame-level results are checked inline by each scenario task.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi2_frame_monitor;

   localparam int c_DW = 10;
   localparam int c_CW = 16;
   localparam int c_TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic            fs = 0, fe = 0, ls = 0, le = 0, lv = 0, ecc = 0, crc = 0, clr = 0;
   logic [c_DW-1:0] data = '0;
   logic            pix_valid, sof, eol, frame_done, frame_err, proto_err, timeout;
   logic [c_DW-1:0] pix_data;
   logic [c_CW-1:0] width, height, frame_cnt, ecc_cnt, crc_cnt;

   // Second instance with narrow counters for the saturation scenario.
   logic            sat_ecc = 0, sat_clr = 0;
   logic            sat_pv, sat_sof, sat_eol, sat_fd, sat_fe, sat_pe, sat_to;
   logic [c_DW-1:0] sat_pd;
   logic [3:0]      sat_w, sat_h, sat_fc, sat_ec, sat_cc;

   csi2_frame_monitor #(.g_DATAWIDTH(c_DW), .g_CNT_WIDTH(c_CW), .g_TIMEOUT(c_TO)) u_dut (
      .PARALLEL_CLOCK_I(clk), .RESET_I(rst),
      .FRAME_START_I(fs), .FRAME_END_I(fe), .LINE_START_I(ls), .LINE_END_I(le),
      .LINE_VALID_I(lv), .DATA_I(data), .ECC_ERROR_I(ecc), .CRC_ERROR_I(crc), .CLEAR_I(clr),
      .PIX_VALID_O(pix_valid), .PIX_DATA_O(pix_data), .SOF_O(sof), .EOL_O(eol),
      .WIDTH_O(width), .HEIGHT_O(height), .FRAME_DONE_O(frame_done), .FRAME_ERR_O(frame_err),
      .PROTO_ERR_O(proto_err), .TIMEOUT_O(timeout), .FRAME_CNT_O(frame_cnt),
      .ECC_CNT_O(ecc_cnt), .CRC_CNT_O(crc_cnt)
   );

   csi2_frame_monitor #(.g_DATAWIDTH(c_DW), .g_CNT_WIDTH(4), .g_TIMEOUT(c_TO)) u_sat (
      .PARALLEL_CLOCK_I(clk), .RESET_I(rst),
      .FRAME_START_I(1'b0), .FRAME_END_I(1'b0), .LINE_START_I(1'b0), .LINE_END_I(1'b0),
      .LINE_VALID_I(1'b0), .DATA_I(10'd0), .ECC_ERROR_I(sat_ecc), .CRC_ERROR_I(1'b0),
      .CLEAR_I(sat_clr),
      .PIX_VALID_O(sat_pv), .PIX_DATA_O(sat_pd), .SOF_O(sat_sof), .EOL_O(sat_eol),
      .WIDTH_O(sat_w), .HEIGHT_O(sat_h), .FRAME_DONE_O(sat_fd), .FRAME_ERR_O(sat_fe),
      .PROTO_ERR_O(sat_pe), .TIMEOUT_O(sat_to), .FRAME_CNT_O(sat_fc),
      .ECC_CNT_O(sat_ec), .CRC_CNT_O(sat_cc)
   );

   typedef struct packed {
      logic [c_DW-1:0] data;
      logic            sof;
      logic            eol;
      logic [31:0]     cyc;
   } pix_t;

   pix_t        exp_q[$];
   pix_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          done_cnt = 0, proto_cnt = 0, to_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every valid beat.
   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (proto_err === 1'b1) proto_cnt++;
      if (timeout === 1'b1) to_cnt++;
      if (pix_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pix_unexpected: got beat data=%h sof=%b eol=%b at cycle %0d, required no beat",
                     pix_data, sof, eol, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (pix_data !== mon_e.data || sof !== mon_e.sof || eol !== mon_e.eol || cyc !== mon_e.cyc) begin
               errors++;
               $display("FAIL pix_beat: got data=%h sof=%b eol=%b cycle=%0d, required data=%h sof=%b eol=%b cycle=%0d",
                        pix_data, sof, eol, cyc, mon_e.data, mon_e.sof, mon_e.eol, mon_e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      fs = 0; fe = 0; ls = 0; le = 0; lv = 0; ecc = 0; crc = 0; clr = 0;
      sat_ecc = 0; sat_clr = 0; data = '0;
   endtask

   // One line: LS cycle, then n pixels with LE on the last; the first ecc_n /
   // crc_n pixel cycles also carry an ECC / CRC pulse.
   task automatic send_line(input int n, input bit first, input int ecc_n, input int crc_n);
      ls = 1;
      step();
      for (int i = 0; i < n; i++) begin
         lv   = 1;
         data = c_DW'($urandom_range(0, 1023));
         le   = (i == n - 1);
         ecc  = (i < ecc_n);
         crc  = (i < crc_n);
         exp_q.push_back('{data: data, sof: (first && i == 0), eol: (i == n - 1), cyc: cyc + 32'd2});
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) step();
      checks++;
      if ({pix_valid, sof, eol, frame_done, frame_err, proto_err, timeout} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 0000000",
                  {pix_valid, sof, eol, frame_done, frame_err, proto_err, timeout});
      end
      checks++;
      if ({width, height, frame_cnt, ecc_cnt, crc_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_values: got w=%0d h=%0d fc=%0d ecc=%0d crc=%0d, required all 0",
                  width, height, frame_cnt, ecc_cnt, crc_cnt);
      end
      rst = 0;
      step();
   endtask

   task automatic test_normal_frame();
      fs = 1; step();
      for (int l = 0; l < 4; l++) send_line(8, l == 0, 0, 0);
      fe = 1; step();
      checks++;
      if ({frame_done, frame_err} !== 2'b10 || width !== 8 || height !== 4 || frame_cnt !== 1) begin
         errors++;
         $display("FAIL normal_done: got done=%b err=%b w=%0d h=%0d fc=%0d, required done=1 err=0 w=8 h=4 fc=1",
                  frame_done, frame_err, width, height, frame_cnt);
      end
      step();
      checks++;
      if (frame_done !== 1'b0 || width !== 8) begin
         errors++;
         $display("FAIL normal_hold: got done=%b w=%0d, required done=0 w=8", frame_done, width);
      end
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL normal_drain: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_line_mismatch();
      int widths[4] = '{8, 8, 7, 8};
      fs = 1; step();
      for (int l = 0; l < 4; l++) send_line(widths[l], l == 0, 0, 0);
      fe = 1; step();
      checks++;
      if ({frame_done, frame_err} !== 2'b11 || width !== 8 || height !== 4 || frame_cnt !== 2) begin
         errors++;
         $display("FAIL mismatch_done: got done=%b err=%b w=%0d h=%0d fc=%0d, required done=1 err=1 w=8 h=4 fc=2",
                  frame_done, frame_err, width, height, frame_cnt);
      end
      repeat (4) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mismatch_drain: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_protocol();
      int p0 = proto_cnt;
      int d0 = done_cnt;
      fs = 1; step();
      ls = 1; step();
      for (int i = 0; i < 3; i++) begin
         lv   = 1;
         data = c_DW'($urandom_range(0, 1023));
         exp_q.push_back('{data: data, sof: (i == 0), eol: (i == 2), cyc: cyc + 32'd2});
         step();
      end
      fs = 1; step();
      for (int l = 0; l < 2; l++) send_line(4, l == 0, 0, 0);
      fe = 1; step();
      checks++;
      if ({frame_done, frame_err} !== 2'b10 || width !== 4 || height !== 2) begin
         errors++;
         $display("FAIL proto_done: got done=%b err=%b w=%0d h=%0d, required done=1 err=0 w=4 h=2",
                  frame_done, frame_err, width, height);
      end
      repeat (4) step();
      checks++;
      if (proto_cnt - p0 != 1 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL proto_pulses: got proto=%0d done=%0d, required proto=1 done=1",
                  proto_cnt - p0, done_cnt - d0);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL proto_drain: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_counters();
      clr = 1; step();
      checks++;
      if (frame_cnt !== 0 || ecc_cnt !== 0 || crc_cnt !== 0) begin
         errors++;
         $display("FAIL clear: got fc=%0d ecc=%0d crc=%0d, required all 0", frame_cnt, ecc_cnt, crc_cnt);
      end
      fs = 1; step();
      send_line(4, 1, 3, 0);
      send_line(4, 0, 0, 2);
      fe = 1; step();
      checks++;
      if ({frame_done, frame_err} !== 2'b11 || width !== 4 || height !== 2 || frame_cnt !== 1) begin
         errors++;
         $display("FAIL crc_frame: got done=%b err=%b w=%0d h=%0d fc=%0d, required done=1 err=1 w=4 h=2 fc=1",
                  frame_done, frame_err, width, height, frame_cnt);
      end
      checks++;
      if (ecc_cnt !== 3 || crc_cnt !== 2) begin
         errors++;
         $display("FAIL err_counts: got ecc=%0d crc=%0d, required ecc=3 crc=2", ecc_cnt, crc_cnt);
      end
      repeat (3) step();
      ecc = 1; clr = 1; step();
      checks++;
      if (ecc_cnt !== 0 || crc_cnt !== 0 || frame_cnt !== 0) begin
         errors++;
         $display("FAIL clear_wins: got ecc=%0d crc=%0d fc=%0d, required all 0", ecc_cnt, crc_cnt, frame_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL counters_drain: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 14; i++) begin
         sat_ecc = 1; step();
      end
      checks++;
      if (sat_ec !== 4'd14) begin
         errors++;
         $display("FAIL sat_count: got %0d, required 14", sat_ec);
      end
      for (int i = 0; i < 3; i++) begin
         sat_ecc = 1; step();
      end
      checks++;
      if (sat_ec !== 4'hF) begin
         errors++;
         $display("FAIL sat_hold: got %0d, required 15", sat_ec);
      end
      sat_ecc = 1; sat_clr = 1; step();
      checks++;
      if (sat_ec !== 4'd0) begin
         errors++;
         $display("FAIL sat_clear: got %0d, required 0", sat_ec);
      end
   endtask

   task automatic test_timeout();
      int t0 = to_cnt;
      int p0 = proto_cnt;
      int d0 = done_cnt;
      fs = 1; step();
      ls = 1; step();
      repeat (c_TO - 1) step();
      checks++;
      if (timeout !== 1'b0 || to_cnt != t0) begin
         errors++;
         $display("FAIL timeout_early: got timeout=%b pulses=%0d, required 0 and 0", timeout, to_cnt - t0);
      end
      step();
      checks++;
      if (timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fire: got %b, required 1", timeout);
      end
      step();
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: got %b, required 0", timeout);
      end
      ls = 1; lv = 1; data = 10'h155; step();
      lv = 1; data = 10'h0AA; le = 1; step();
      repeat (4) step();
      checks++;
      if (proto_cnt != p0 || done_cnt != d0 || to_cnt - t0 != 1) begin
         errors++;
         $display("FAIL timeout_after: got proto=%0d done=%0d timeouts=%0d, required 0 0 1",
                  proto_cnt - p0, done_cnt - d0, to_cnt - t0);
      end
   endtask

   task automatic test_reset_mid_line();
      int d0 = done_cnt;
      fs = 1; step();
      ls = 1; step();
      for (int i = 0; i < 4; i++) begin
         lv   = 1;
         data = c_DW'($urandom_range(0, 1023));
         if (i < 3) exp_q.push_back('{data: data, sof: (i == 0), eol: 1'b0, cyc: cyc + 32'd2});
         step();
      end
      rst = 1; step();
      checks++;
      if ({pix_valid, sof, eol, frame_done, frame_err, proto_err, timeout} !== 7'b0 ||
          {width, height, frame_cnt, ecc_cnt, crc_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got flags=%b w=%0d h=%0d fc=%0d, required all 0",
                  {pix_valid, sof, eol, frame_done, frame_err, proto_err, timeout}, width, height, frame_cnt);
      end
      rst = 0; step();
      fs = 1; step();
      for (int l = 0; l < 3; l++) send_line(6, l == 0, 0, 0);
      fe = 1; step();
      checks++;
      if ({frame_done, frame_err} !== 2'b10 || width !== 6 || height !== 3 || frame_cnt !== 1) begin
         errors++;
         $display("FAIL post_reset_frame: got done=%b err=%b w=%0d h=%0d fc=%0d, required done=1 err=0 w=6 h=3 fc=1",
                  frame_done, frame_err, width, height, frame_cnt);
      end
      repeat (4) step();
      checks++;
      if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset_drain: got done=%0d pending=%0d, required done=1 pending=0",
                  done_cnt - d0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_line_mismatch();
      test_protocol();
      test_counters();
      test_saturation();
      test_timeout();
      test_reset_mid_line();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
